// File: rtl/des_sbox_sequencer.sv
// des_sbox_sequencer: time-multiplexes one DES S-box bank across the eight 6-bit slices of a 48-bit word
module des_sbox_sequencer #(
  parameter int SBOX_LAT = 0,
  parameter int NUM_BOXES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [0:47] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [0:31] out_data,
  output logic        sbox_req,
  output logic [2:0]  sbox_sel,
  output logic [0:5]  sbox_in,
  input  logic [0:3]  sbox_out,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state;
  logic [0:47] data;
  logic [2:0] index;
  logic cap, last, iss;
  if (SBOX_LAT < 0 || SBOX_LAT > 1 || NUM_BOXES != 8) begin : g_bad_param
    $error("des_sbox_sequencer: SBOX_LAT must be 0 or 1 and NUM_BOXES must be 8");
  end
  assign busy = !in_ready;
  // a result is due one cycle after a strobe (zero-latency bank) or after the quiet wait cycle (registered bank)
  always_comb begin
    cap = (state == ISSUE && SBOX_LAT == 0 && sbox_req) || (state == WAIT && !sbox_req);
    last = cap && sbox_sel == 3'd7;
    iss = (state == ISSUE || (state == WAIT && cap)) && !last;
  end
  // sequencing, bank drive and result assembly; flush outranks every handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      out_data <= '0;
      sbox_req <= 1'b0;
      sbox_sel <= '0;
      sbox_in <= '0;
      data <= '0;
      index <= '0;
    end else if (flush) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      sbox_req <= 1'b0;
      index <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        state <= ISSUE;
        in_ready <= 1'b0;
        data <= in_data;
        out_data <= '0;
        index <= '0;
      end
      if (state == DONE && out_ready) begin
        state <= IDLE;
        out_valid <= 1'b0;
        in_ready <= 1'b1;
      end
      if (cap) out_data[4*sbox_sel +: 4] <= sbox_out;
      sbox_req <= iss;
      if (iss) begin
        sbox_sel <= index;
        sbox_in <= data[6*index +: 6];
        index <= index + {2'b0, index != 3'd7};
        if (SBOX_LAT == 1) state <= WAIT;
      end
      if (last) begin
        state <= DONE;
        out_valid <= 1'b1;
        index <= '0;
      end
    end
  end
endmodule

// File: tb/tb_des_sbox_sequencer.sv
// tb_des_sbox_sequencer: checks the sequencer at both bank latencies against a table-level DES S-box model
module tb_des_sbox_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n [2];
  logic flush [2];
  logic in_valid [2];
  logic out_ready [2];
  logic [0:47] in_data [2];
  wire in_ready [2];
  wire out_valid [2];
  wire [0:31] out_data [2];
  wire sbox_req [2];
  wire [2:0] sbox_sel [2];
  wire [0:5] sbox_in [2];
  wire busy [2];
  logic [0:3] so0, so1;
  int sb [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};
  function automatic logic [0:3] sbox(input int k, input logic [0:5] x);
    return 4'(sb[k][{x[0], x[5]} * 16 + x[1:4]]);
  endfunction
  function automatic logic [0:31] model_out(input logic [0:47] w);
    logic [0:31] r;
    for (int k = 0; k < 8; k++) r[4*k +: 4] = sbox(k, w[6*k +: 6]);
    return r;
  endfunction
  function automatic logic [63:0] exp_req(input int l);
    logic [63:0] p = '0;
    for (int i = 1; i <= 8 * (l + 1); i++) if ((i - 1) % (l + 1) == 0) p[i] = 1'b1;
    return p;
  endfunction
  function automatic logic [44:0] view(input int d);
    return {in_ready[d], out_valid[d], out_data[d], sbox_req[d], sbox_sel[d], sbox_in[d], busy[d]};
  endfunction
  des_sbox_sequencer #(.SBOX_LAT(0)) u0 (.clk(clk), .rst_n(rst_n[0]), .flush(flush[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .sbox_req(sbox_req[0]), .sbox_sel(sbox_sel[0]), .sbox_in(sbox_in[0]),
    .sbox_out(so0), .busy(busy[0]));
  des_sbox_sequencer #(.SBOX_LAT(1)) u1 (.clk(clk), .rst_n(rst_n[1]), .flush(flush[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .sbox_req(sbox_req[1]), .sbox_sel(sbox_sel[1]), .sbox_in(sbox_in[1]),
    .sbox_out(so1), .busy(busy[1]));
  always_comb so0 = sbox(sbox_sel[0], sbox_in[0]);
  always_ff @(posedge clk) so1 <= sbox(sbox_sel[1], sbox_in[1]);
  int total, bad;
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  logic [0:31] res;
  int lat;
  logic [63:0] reqpat;
  logic [23:0] sels;
  logic stable, rdy;
  task automatic run_word(input int d, input logic [0:47] w, input int hold);
    int n;
    @(negedge clk);
    in_data[d] = w;
    in_valid[d] = 1'b1;
    out_ready[d] = 1'b0;
    n = 0;
    while (!in_ready[d] && n < 100) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 in_valid[d] = 1'b0;
    lat = 0;
    reqpat = '0;
    sels = '0;
    while (!out_valid[d] && lat < 40) begin
      @(posedge clk);
      #1 lat++;
      if (sbox_req[d]) begin reqpat[lat] = 1'b1; sels = {sels[20:0], sbox_sel[d]}; end
    end
    res = out_data[d];
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1 if (!out_valid[d] || out_data[d] !== res || in_ready[d]) stable = 1'b0;
    end
    @(negedge clk) out_ready[d] = 1'b1;
    @(posedge clk);
    #1 out_ready[d] = 1'b0;
    rdy = in_ready[d] && !out_valid[d];
  endtask
  typedef struct { logic [0:47] din; logic [0:31] dout; } vec_t;
  vec_t vt [3];
  int exp_lat [2] = '{9, 17};
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [0:47] w, w2;
    int n, acc, nh;
    int at [2];
    int ht [2];
    logic [0:31] hd [2];
    logic seen;
    total = 0;
    bad = 0;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0;
      flush[d] = 1'b0;
      in_valid[d] = 1'b0;
      out_ready[d] = 1'b0;
      in_data[d] = '0;
    end
    #12;
    for (int d = 0; d < 2; d++) check($sformatf("reset_state_%0d", d), view(d), {1'b1, 44'h0});
    @(negedge clk);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    vt[0] = '{48'h000000000000, 32'hEFA72C4D};
    vt[1] = '{48'h6117BA866527, 32'h5C82B597};
    vt[2] = '{48'hFFFFFFFFFFFF, 32'hD9CE3DCB};
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 3; i++) begin
        run_word(d, vt[i].din, 0);
        check($sformatf("vec%0d_lat%0d_data", i, d), res, vt[i].dout);
        check($sformatf("vec%0d_lat%0d_latency", i, d), lat, exp_lat[d]);
        check($sformatf("vec%0d_lat%0d_reqpattern", i, d), reqpat, exp_req(d));
        check($sformatf("vec%0d_lat%0d_selseq", i, d), sels, 24'o01234567);
        check($sformatf("vec%0d_lat%0d_ready_after", i, d), rdy, 1);
      end
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 8; i++) begin
        w = {$urandom, 16'($urandom)};
        run_word(d, w, $urandom_range(0, 3));
        check($sformatf("rand%0d_lat%0d_data", i, d), res, model_out(w));
        check($sformatf("rand%0d_lat%0d_latency", i, d), lat, exp_lat[d]);
        check($sformatf("rand%0d_lat%0d_hold", i, d), stable, 1);
      end
    w = {$urandom, 16'($urandom)};
    run_word(0, w, 20);
    check("backpressure_data", res, model_out(w));
    check("backpressure_stable", stable, 1);
    check("backpressure_ready_next", rdy, 1);
    w = {$urandom, 16'($urandom)};
    w2 = {$urandom, 16'($urandom)};
    at = '{-100, -100};
    ht = '{-100, -100};
    acc = 0;
    nh = 0;
    @(negedge clk);
    in_data[0] = w;
    in_valid[0] = 1'b1;
    out_ready[0] = 1'b1;
    for (int c = 0; c < 80 && nh < 2; c++) begin
      if (in_valid[0] && in_ready[0] && acc < 2) begin at[acc] = c; acc++; end
      if (out_valid[0]) begin ht[nh] = c; hd[nh] = out_data[0]; nh++; end
      @(negedge clk);
      if (acc == 1) in_data[0] = w2;
      if (acc == 2) in_valid[0] = 1'b0;
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b0;
    check("b2b_outputs", nh, 2);
    check("b2b_accept_gap", at[1] - ht[0], 1);
    check("b2b_first", hd[0], model_out(w));
    check("b2b_second", hd[1], model_out(w2));
    w = {$urandom, 16'($urandom)};
    @(negedge clk);
    in_data[0] = w;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    n = 0;
    while (!(sbox_req[0] && sbox_sel[0] == 3'd4) && n < 20) begin @(posedge clk); #1 n++; end
    check("flush_reach_index4", n < 20, 1);
    @(negedge clk) flush[0] = 1'b1;
    @(posedge clk);
    #1 flush[0] = 1'b0;
    check("flush_idle", {in_ready[0], out_valid[0], sbox_req[0], busy[0]}, 4'b1000);
    seen = 1'b0;
    repeat (12) begin @(posedge clk); #1 if (out_valid[0]) seen = 1'b1; end
    check("flush_no_out", seen, 0);
    run_word(0, 48'h0, 0);
    check("flush_next_word", res, 32'hEFA72C4D);
    check("flush_next_latency", lat, 9);
    @(negedge clk);
    flush[0] = 1'b1;
    in_valid[0] = 1'b1;
    in_data[0] = 48'h6117BA866527;
    @(posedge clk);
    #1 flush[0] = 1'b0;
    in_valid[0] = 1'b0;
    check("flush_idle_no_accept", {in_ready[0], busy[0]}, 2'b10);
    @(negedge clk);
    in_data[0] = 48'h6117BA866527;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    n = 0;
    while (!out_valid[0] && n < 20) begin @(posedge clk); #1 n++; end
    check("done_reach", out_valid[0], 1);
    @(negedge clk);
    flush[0] = 1'b1;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1 flush[0] = 1'b0;
    out_ready[0] = 1'b0;
    check("flush_done_drop", {in_ready[0], out_valid[0], busy[0]}, 3'b100);
    @(negedge clk);
    in_data[1] = 48'h6117BA866527;
    in_valid[1] = 1'b1;
    @(posedge clk);
    #1 in_valid[1] = 1'b0;
    n = 0;
    while (!(busy[1] && !sbox_req[1] && sbox_sel[1] == 3'd3) && n < 30) begin @(posedge clk); #1 n++; end
    check("wait_reach", n < 30, 1);
    #2 rst_n[1] = 1'b0;
    #1 check("async_reset_midwait", view(1), {1'b1, 44'h0});
    @(negedge clk) rst_n[1] = 1'b1;
    run_word(1, 48'h6117BA866527, 0);
    check("after_reset_data", res, 32'h5C82B597);
    check("after_reset_latency", lat, 17);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
